// File: rtl/dl_mem_arbiter.sv
// Shares one sync RAM between a 2-entry download FIFO (priority, drops+dn_ovf when full) and a CPU req/ack port;
// CPU write ack 1 cycle / read ack 2 cycles after grant; holds cpu_reset through downloads. DL_CHECKSUM_EN adds dn_sum.
module dl_mem_arbiter #(
    parameter logic [7:0] DN_INDEX    = 8'd0,
    parameter int         HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [13:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic [7:0]  dn_index,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_dout,
    output logic        cpu_reset,
    output logic        dn_ovf,
    output logic [7:0]  dn_sum
);
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CPU_WR,
        CPU_RD1,
        CPU_RD2,
        DN_WR,
        HOLD
    } state_t;

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } dn_entry_t;

    state_t     state;
    state_t     state_nxt;
    dn_entry_t  fifo_q [2];
    dn_entry_t  fifo_head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_cnt;
    logic       fifo_empty;
    logic       fifo_full;
    logic       active;
    logic       active_q;
    logic       dn_start;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       ovf_event;
    logic [7:0] hold_cnt;

    assign active     = dn_download && (dn_index == DN_INDEX);
    assign dn_start   = active && !active_q;
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign fifo_full  = (fifo_cnt == 2'd2);
    assign fifo_head  = fifo_q[rd_ptr];
    assign push_req   = active && dn_wr;
    assign pop        = (state_nxt == DN_WR);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_event  = push_req && fifo_full && !pop;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{addr: dn_addr, data: dn_data};
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // HOLD behaves like IDLE but marks that the CPU is parked in reset.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HOLD: begin
                if (!fifo_empty) begin
                    state_nxt = DN_WR;
                end else if (cpu_req && !cpu_reset) begin
                    state_nxt = cpu_we ? CPU_WR : CPU_RD1;
                end else if (cpu_reset) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CPU_WR:  state_nxt = IDLE;
            CPU_RD1: state_nxt = CPU_RD2;
            CPU_RD2: state_nxt = IDLE;
            DN_WR:   state_nxt = fifo_empty ? IDLE : DN_WR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state_nxt)
                DN_WR: begin
                    mem_addr <= fifo_head.addr;
                    mem_din  <= fifo_head.data;
                    mem_we   <= 1'b1;
                end
                CPU_WR: begin
                    mem_addr <= cpu_addr;
                    mem_din  <= cpu_din;
                    mem_we   <= 1'b1;
                end
                CPU_RD1: begin
                    mem_addr <= cpu_addr;
                end
                default: begin
                end
            endcase
        end
    end

    // RAM read data arrives during CPU_RD2, so the ack path is a state decode.
    assign cpu_ack  = (state == CPU_WR) || (state == CPU_RD2);
    assign cpu_dout = (state == CPU_RD2) ? mem_dout : 8'd0;

    // Countdown only once the download is over and its last byte is in RAM.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cpu_reset <= 1'b1;
            hold_cnt  <= HOLD_INIT;
        end else if (active) begin
            cpu_reset <= 1'b1;
            hold_cnt  <= HOLD_INIT;
        end else if (cpu_reset && fifo_empty && (state != DN_WR)) begin
            if (hold_cnt <= 8'd1) begin
                cpu_reset <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            dn_ovf   <= 1'b0;
        end else begin
            active_q <= active;
            dn_ovf   <= (dn_ovf && !dn_start) || ovf_event;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else if (dn_start) begin
            sum_q <= 8'd0;
        end else if (pop) begin
            sum_q <= sum_q + fifo_head.data;
        end
    end

    assign dn_sum = sum_q;
`else
    assign dn_sum = 8'd0;
`endif

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// Randomized scoreboard bench for dl_mem_arbiter with a behavioural RAM and expected-memory model.
`timescale 1ns/1ps
module tb_dl_mem_arbiter;
    localparam logic [7:0] DNI  = 8'd0;
    localparam int         HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        dn_download = 1'b0;
    logic        dn_wr = 1'b0;
    logic [13:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic [7:0]  dn_index = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic [13:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic        cpu_reset;
    logic        dn_ovf;
    logic [7:0]  dn_sum;

    always #5 clk_sys = ~clk_sys;

    dl_mem_arbiter #(.DN_INDEX(DNI), .HOLD_CYCLES(HOLD)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .cpu_reset(cpu_reset), .dn_ovf(dn_ovf), .dn_sum(dn_sum)
    );

    logic [7:0] ram [0:16383];
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    typedef struct packed { logic [13:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic rd; logic [7:0] data; } ack_t;

    wr_t         wq[$];
    ack_t        aq[$];
    logic [13:0] waddrs[$];
    logic [7:0]  exp_mem [0:16383];
    logic [7:0]  exp_sum = 8'd0;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int fall_cyc = 0;
    int we_cnt = 0;
    int cr_hi_cnt = 0;
    logic prev_cr = 1'b1;
    wr_t  mon_w;
    ack_t mon_a;

    logic [13:0] dl_a [8];
    logic [7:0]  dl_d [8];
    int          dl_g [8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_sum_out();
`ifdef DL_CHECKSUM_EN
        return exp_sum;
`else
        return 8'd0;
`endif
    endfunction

    always @(negedge clk_sys) begin
        cyc++;
        if (!reset) begin
            if (mem_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                if (wq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_mem_we: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_din);
                end else begin
                    mon_w = wq.pop_front();
                    chk("mem_addr", mem_addr, mon_w.addr);
                    chk("mem_din", mem_din, mon_w.data);
                end
            end
            if (cpu_ack) begin
                if (aq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_cpu_ack: got ack, expected none");
                end else begin
                    mon_a = aq.pop_front();
                    if (mon_a.rd) chk("cpu_dout", cpu_dout, mon_a.data);
                end
            end
            if (cpu_reset) cr_hi_cnt++;
            if (prev_cr && !cpu_reset) fall_cyc = cyc;
        end
        prev_cr = cpu_reset;
    end

    task automatic do_reset();
        int n;
        int we0;
        reset = 1'b1;
        cpu_req = 1'b0; dn_download = 1'b0; dn_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_dn_ovf", dn_ovf, 0);
        chk("rst_dn_sum", dn_sum, 0);
        wq.delete();
        aq.delete();
        we0 = we_cnt;
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (cpu_reset && n < 100);
        chk("reset_hold_cycles", n, HOLD);
        chk("writes_during_reset_hold", we_cnt - we0, 0);
    endtask

    task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d, input int exp_lat);
        int n;
        @(negedge clk_sys);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        if (we) begin
            exp_mem[a] = d;
            waddrs.push_back(a);
            wq.push_back(wr_t'{addr: a, data: d});
            aq.push_back(ack_t'{rd: 1'b0, data: d});
        end else begin
            aq.push_back(ack_t'{rd: 1'b1, data: exp_mem[a]});
        end
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!cpu_ack && n < 20);
        cpu_req = 1'b0;
        chk(we ? "cpu_wr_latency" : "cpu_rd_latency", n, exp_lat);
    endtask

    task automatic dn_byte(input logic [13:0] a, input logic [7:0] d, input int gap, input bit expect_write);
        dn_wr = 1'b1; dn_addr = a; dn_data = d;
        if (expect_write) begin
            wq.push_back(wr_t'{addr: a, data: d});
            exp_mem[a] = d;
            waddrs.push_back(a);
            exp_sum = exp_sum + d;
        end
        @(negedge clk_sys);
        dn_wr = 1'b0;
        repeat (gap - 1) @(negedge clk_sys);
    endtask

    task automatic finish_download(input logic exp_ovf);
        int n;
        n = 0;
        while (cpu_reset && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        @(negedge clk_sys);
        chk("cpu_reset_release_in_time", n < 400, 1);
        chk("hold_after_last_write", fall_cyc - last_we_cyc, HOLD + 1);
        chk("dn_ovf", dn_ovf, exp_ovf);
        chk("dn_sum", dn_sum, exp_sum_out());
        chk("writes_drained", wq.size(), 0);
    endtask

    task automatic run_download(input logic [7:0] idx, input int n);
        bit match;
        int we0;
        int cr0;
        match = (idx == DNI);
        we0 = we_cnt;
        cr0 = cr_hi_cnt;
        @(negedge clk_sys);
        dn_download = 1'b1; dn_index = idx;
        if (match) exp_sum = 8'd0;
        @(negedge clk_sys);
        chk("cpu_reset_on_start", cpu_reset, match);
        for (int i = 0; i < n; i++) dn_byte(dl_a[i], dl_d[i], (i == n - 1) ? 1 : dl_g[i], match);
        dn_download = 1'b0;
        if (match) begin
            finish_download(1'b0);
        end else begin
            repeat (20) @(negedge clk_sys);
            chk("foreign_index_writes", we_cnt - we0, 0);
            chk("foreign_index_cpu_reset", cr_hi_cnt - cr0, 0);
        end
    endtask

    initial begin
        int nops;
        int dl_n;
        logic [7:0] idx;
        logic [13:0] a;

        do_reset();

        cpu_access(1'b1, 14'h0100, 8'h5A, 1);
        cpu_access(1'b0, 14'h0100, 8'h00, 2);

        for (int i = 0; i < 3; i++) begin
            dl_a[i] = 14'(i);
            dl_d[i] = 8'(i + 1);
            dl_g[i] = 4;
        end
        run_download(DNI, 3);

        run_download(8'd1, 3);

        // Read granted in the very cycle the first byte arrives.
        fork
            cpu_access(1'b0, 14'h0100, 8'h00, 2);
            begin
                @(negedge clk_sys);
                dn_download = 1'b1; dn_index = DNI; exp_sum = 8'd0;
                dn_byte(14'h0200, 8'hA7, 1, 1'b1);
                dn_download = 1'b0;
            end
        join
        finish_download(1'b0);

        // Back-to-back strobes while a read owns the RAM: third byte must drop.
        fork
            cpu_access(1'b0, 14'h0100, 8'h00, 2);
            begin
                @(negedge clk_sys);
                dn_download = 1'b1; dn_index = DNI; exp_sum = 8'd0;
                dn_byte(14'h0210, 8'h11, 1, 1'b1);
                dn_byte(14'h0211, 8'h22, 1, 1'b1);
                dn_byte(14'h0212, 8'h33, 1, 1'b0);
                dn_download = 1'b0;
            end
        join
        finish_download(1'b1);

        for (int r = 0; r < 6; r++) begin
            nops = $urandom_range(2, 5);
            for (int k = 0; k < nops; k++) begin
                if (waddrs.size() == 0 || $urandom_range(0, 1) == 1) begin
                    a = 14'h1000 + 14'($urandom_range(0, 255));
                    cpu_access(1'b1, a, 8'($urandom_range(0, 255)), 1);
                end else begin
                    a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                    cpu_access(1'b0, a, 8'h00, 2);
                end
            end
            dl_n = $urandom_range(1, 6);
            for (int i = 0; i < dl_n; i++) begin
                dl_a[i] = 14'h2000 + 14'($urandom_range(0, 255));
                dl_d[i] = 8'($urandom_range(0, 255));
                dl_g[i] = $urandom_range(2, 5);
            end
            idx = (r == 3) ? 8'($urandom_range(1, 255)) : DNI;
            run_download(idx, dl_n);
        end

        chk("acks_drained", aq.size(), 0);

        // Reset during a read with a byte queued: no ack, byte discarded.
        @(negedge clk_sys);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0100;
        dn_download = 1'b1; dn_index = DNI; dn_wr = 1'b1; dn_addr = 14'h0300; dn_data = 8'hEE;
        @(negedge clk_sys);
        reset = 1'b1; cpu_req = 1'b0; dn_wr = 1'b0; dn_download = 1'b0;
        #1;
        chk("abort_no_ack", cpu_ack, 0);
        chk("abort_no_we", mem_we, 0);
        do_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end
endmodule

// File: doc/dl_mem_arbiter.md
DL_MEM_ARBITER -- requirements
Module: dl_mem_arbiter

Interface
REQ-001 SHALL have parameter DN_INDEX, default 8'd0: the dn_index value whose downloads target the shared RAM.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: the number of cycles cpu_reset stays high after a download ends (range 1..255).
REQ-003 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 dn_download  in  1  a download is in progress.
REQ-006 dn_wr  in  1  single-cycle byte strobe.
REQ-007 dn_addr  in  14  download byte address.
REQ-008 dn_data  in  8  download byte.
REQ-009 dn_index  in  8  download file index.
REQ-010 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-011 cpu_we  in  1  1 = write, 0 = read; sampled together with cpu_req.
REQ-012 cpu_addr  in  14  CPU address.
REQ-013 cpu_din  in  8  CPU write data.
REQ-014 cpu_ack  out  1  one-cycle completion pulse.
REQ-015 cpu_dout  out  8  read data; valid while cpu_ack is high.
REQ-016 mem_addr  out  14  RAM address (registered).
REQ-017 mem_din  out  8  RAM write data (registered).
REQ-018 mem_we  out  1  RAM write enable (registered).
REQ-019 mem_dout  in  8  RAM read data; synchronous, 1-cycle latency.
REQ-020 cpu_reset  out  1  holds the CPU in reset.
REQ-021 dn_ovf  out  1  sticky flag: a download FIFO overflow occurred.
REQ-022 dn_sum  out  8  checksum of downloaded bytes (see Configuration).

Function
REQ-023 A download SHALL be active only while dn_download=1 and dn_index==DN_INDEX; dn_wr strobes at any other time SHALL be ignored.
REQ-024 Bytes from an active download SHALL be pushed into a 2-entry {addr,data} FIFO. A push while the FIFO is full SHALL drop the byte and set dn_ovf.
REQ-025 A simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-026 The FSM SHALL have the states IDLE, CPU_WR, CPU_RD1, CPU_RD2, DN_WR, and HOLD.
REQ-027 In IDLE, if the FIFO is non-empty, the FSM SHALL go to DN_WR. Otherwise, if cpu_req=1 and cpu_reset=0, it SHALL go to CPU_WR when cpu_we=1 and to CPU_RD1 when cpu_we=0. Download has priority over the CPU.
REQ-028 DN_WR SHALL pop the FIFO head and drive mem_addr/mem_din/mem_we=1 for exactly one cycle. It SHALL then go to DN_WR if the FIFO is still non-empty, else to IDLE.
REQ-029 CPU_WR SHALL drive mem_we=1 with cpu_addr/cpu_din, pulse cpu_ack in the same cycle, then return to IDLE. CPU write latency is 1 cycle after grant.
REQ-030 CPU_RD1 SHALL drive mem_addr=cpu_addr with mem_we=0. CPU_RD2 SHALL pulse cpu_ack with cpu_dout=mem_dout, then return to IDLE. CPU read latency is 2 cycles after grant.
REQ-031 A CPU access already granted when a download starts SHALL complete normally. The queued bytes SHALL be written afterwards, with no byte lost, provided strobes are at least 2 cycles apart.
REQ-032 cpu_reset SHALL assert on the cycle after an active download is detected.
REQ-033 When the download ends, cpu_reset SHALL stay high until the FIFO is empty and then for exactly HOLD_CYCLES further cycles (HOLD counter), then deassert.
REQ-034 A new download that starts during HOLD SHALL reload the counter and keep cpu_reset high.
REQ-035 The start of a new active download SHALL clear dn_ovf and dn_sum.
REQ-036 mem_we SHALL be 0 in every state except CPU_WR and DN_WR.
REQ-037 cpu_ack SHALL never pulse twice for one request.

Reset
REQ-038 Reset SHALL set: FSM=IDLE, FIFO empty, cpu_ack=0, cpu_dout=0, mem_addr=0, mem_din=0, mem_we=0, cpu_reset=1, HOLD counter=HOLD_CYCLES, dn_ovf=0, dn_sum=0.
REQ-039 After reset is released, cpu_reset SHALL run the HOLD countdown before deasserting.
REQ-040 Reset asserted mid-access or mid-download SHALL abort immediately with no pending cpu_ack; queued bytes SHALL be discarded.

Configuration
REQ-041 With macro DL_CHECKSUM_EN defined, dn_sum SHALL be the modulo-256 sum of every byte written in DN_WR since the last download start.
REQ-042 Without DL_CHECKSUM_EN, dn_sum SHALL be constant 0 and no adder SHALL be built.

Verification
REQ-043 Reset release, no download -> cpu_reset falls exactly 16 cycles after reset deasserts (default parameters).
REQ-044 CPU write 0x5A to 0x0100, then read of 0x0100 -> write ack 1 cycle after grant; read ack 2 cycles after grant with cpu_dout=0x5A.
REQ-045 Download index 0 of bytes 0x01,0x02,0x03 to addresses 0..2, strobes 4 cycles apart -> three mem_we pulses with matching addr/data; dn_sum=0x06 when DL_CHECKSUM_EN is defined, else 0; cpu_reset falls 16 cycles after the last write.
REQ-046 Download with index 1 -> no mem_we, cpu_reset unaffected.
REQ-047 CPU read granted in the same cycle as the first dn_wr -> the read acks with correct data, then the byte is written on the following cycles.
REQ-048 Three dn_wr on consecutive cycles while a CPU read holds the RAM -> dn_ovf=1 and exactly 2 bytes written.
